// File: rtl/par2ser_pkg.sv
// rtl/par2ser_pkg.sv - shared state encoding and counter sizing for par2ser_tx
package par2ser_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10
  } state_e;

  localparam int GAP_CNT_W = 4;

  // Bit counter must index 0..w-1; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/shift_reg_ld.sv
// rtl/shift_reg_ld.sv - parallel-load shift register with selectable head bit
module shift_reg_ld #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             c,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             head
);

  logic [WIDTH-1:0] q;

  // Load has priority so a word can be captured regardless of shift enable.
  always_ff @(posedge c) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      if (MSB_FIRST) q <= {q[WIDTH-2:0], 1'b0};
      else           q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign head = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/par2ser_tx.sv
// rtl/par2ser_tx.sv - valid/ready word in, framed serial bit stream out
module par2ser_tx
  import par2ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 1
) (
  input  logic             c,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sdo,
  output logic             sframe,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_e                 state;
  logic [CW-1:0]          bit_cnt;
  logic [GAP_CNT_W-1:0]   gap_cnt;
  logic                   accept;
  logic                   head;
  logic                   in_shift;

  assign in_shift  = (state == S_SHIFT);
  assign din_ready = (state == S_IDLE) && !rst;
  assign accept    = din_valid && din_ready;

  always_ff @(posedge c) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state   <= S_SHIFT;
            bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
            state   <= (GAP > 0) ? S_GAP : S_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  shift_reg_ld #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sreg (
    .c     (c),
    .rst   (rst),
    .load  (accept),
    .shift (in_shift),
    .d     (din),
    .head  (head)
  );

  assign sdo    = in_shift && head;
  assign sframe = in_shift;
  assign busy   = (state != S_IDLE);
  assign done   = in_shift && (bit_cnt == BIT_LAST);

endmodule
